wash_sequencer: RTL and testbench
=================================

Name: wash_sequencer

Overview:
- Program sequencer for the washing register machine.
- Owns the program counter that addresses the instruction ROM (8-bit pc in, 32-bit instr out, combinational read), decodes each instruction, and drives the washer actuator outputs.
- Implements timed waits, loops and jumps, with start/pause/abort operator control.
- Sits between the operator panel/tick generator and the instruction ROM.

Parameters:
- START_PC, 8'h00, pc loaded on start.
- WAIT_W, 20, width of the wait-duration immediate and the wait counter.
- WDOG_MAX, 16'd4095, instructions allowed before the watchdog fault (WATCHDOG_EN only).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins the program from IDLE or DONE
- pause  in  1  level; freezes execution while high
- abort  in  1  one-cycle pulse; returns to IDLE from any state
- tick  in  1  one-cycle 1 Hz timebase strobe; WAIT counts only ticks
- pc  out  8  ROM address
- instr  in  32  ROM data for the current pc
- act  out  4  actuators: [0] valve, [1] heater, [2] motor, [3] drain
- busy  out  1  high in RUN, WAIT and PAUSE
- done  out  1  high in DONE
- err  out  1  sticky illegal-opcode / watchdog flag; cleared by start

Behaviour:
- Reset: clk and rst_n as stated (one clock; reset asynchronous, active-low). All of the following reset to zero: pc, act, busy, done, err, loop_cnt, wait_cnt. State resets to IDLE.
- Instruction format: opcode = instr[31:28], addr = instr[27:20], imm = instr[19:0].
- Execution rate: one instruction per clk in RUN. pc drives the ROM directly; instr is sampled in the same cycle.
- Opcodes and pc update:
  - 0 NOP: pc+1.
  - 1 OUT: act <= imm[3:0] on the next edge; pc+1.
  - 2 WAIT:
    - If imm == 0: pc+1 immediately.
    - Otherwise: wait_cnt <= imm and go to WAIT. Each tick decrements wait_cnt.
    - On the tick that takes wait_cnt from 1 to 0: pc+1 and return to RUN.
    - Total stall is exactly imm ticks. Ticks in the entry cycle are ignored.
  - 3 JMP: pc <= addr.
  - 4 LDC: loop_cnt <= imm[7:0]; pc+1.
  - 5 DJNZ: loop_cnt <= loop_cnt-1. If loop_cnt-1 != 0, pc <= addr; otherwise pc+1. loop_cnt == 0 on entry wraps to 255 and the branch is taken.
  - 6 HALT: go to DONE; act <= 0; pc holds.
  - 7–15: illegal. Set err, then behave as NOP.
- pc increment wraps 8'hFF -> 8'h00.
- States:
  - IDLE: act = 0. start -> pc <= START_PC, err <= 0, RUN.
  - RUN: execute as above.
  - WAIT: count ticks as above.
  - PAUSE: entered from RUN or WAIT while pause is high. pc, wait_cnt, loop_cnt and stored act are frozen. The act output is forced to 0 (door safety) and ticks are ignored. When pause drops, return to the saved state and restore act.
  - DONE: done = 1. start -> restart as from IDLE.
- Priority (same cycle): abort > pause > start > tick.
  - abort in any state -> IDLE, act = 0, pc = 0, counters cleared; err is kept.
  - start while busy is ignored.
  - pause in IDLE/DONE has no effect.
- Asserting rst_n low mid-program clears everything immediately and asynchronously; the program does not resume.

Optional Feature:
- Macro: WATCHDOG_EN.
- Defined: a 16-bit counter increments on each instruction executed in RUN and clears on start or abort. When it reaches WDOG_MAX, set err, force act = 0 and go to DONE.
- Undefined: no counter is present; err comes only from illegal opcodes.

Decomposition:
- Shared package wash_pkg: opcode localparams (OP_NOP .. OP_HALT), state encoding, act bit indices, field position constants.
- Sub-module wash_wait_timer: WAIT_W down-counter with load, tick, freeze and expire. This is the natural split.
- Decode and the FSM stay in the top.

Test Plan:
- Program {0: OUT 4'b0001, 1: WAIT 3, 2: OUT 0, 3: HALT}, start -> act = 1 for exactly 3 ticks after pc=1 is fetched; act=0; done=1 with pc=3.
- Program {0: LDC 3, 1: OUT 4, 2: DJNZ ->1, 3: HALT} -> pc sequence 0,1,2,1,2,1,2,3; done=1; loop_cnt=0.
- Pause high for 5 ticks during WAIT 4 -> act=0 while paused, wait_cnt frozen; after release the stall completes with 4 total counted ticks.
- abort during WAIT -> next cycle state IDLE, pc=0, act=0, busy=0; a new start runs from START_PC.
- Opcode 4'hA at pc=2 -> err=1 and pc=3 next cycle; the next start clears err.
- WATCHDOG_EN with WDOG_MAX=10 and program {0: JMP 0} -> after 10 instructions done=1, err=1, act=0.

Source files
------------

// File: rtl/wash_pkg.sv
// wash_pkg: shared opcodes, state encoding, actuator bits and instruction field positions
package wash_pkg;
  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_OUT  = 4'd1;
  localparam logic [3:0] OP_WAIT = 4'd2;
  localparam logic [3:0] OP_JMP  = 4'd3;
  localparam logic [3:0] OP_LDC  = 4'd4;
  localparam logic [3:0] OP_DJNZ = 4'd5;
  localparam logic [3:0] OP_HALT = 4'd6;
  localparam int OP_LSB   = 28;
  localparam int ADDR_LSB = 20;
  localparam int IMM_W    = 20;
  localparam int ACT_VALVE  = 0;
  localparam int ACT_HEATER = 1;
  localparam int ACT_MOTOR  = 2;
  localparam int ACT_DRAIN  = 3;
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_WAIT, S_PAUSE, S_DONE} state_t;
endpackage

// File: rtl/wash_wait_timer.sv
// wash_wait_timer: W-bit tick down-counter; expire marks the tick that takes it from 1 to 0
module wash_wait_timer #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] val,
  input  logic         tick,
  input  logic         freeze,
  output logic [W-1:0] cnt,
  output logic         expire
);
  logic dec;
  assign dec = tick && !freeze && cnt != '0;
  assign expire = dec && cnt == W'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (load) cnt <= val;
    else if (dec) cnt <= cnt - W'(1);
endmodule

// File: rtl/wash_sequencer.sv
// wash_sequencer: washer program sequencer (fetch/decode/FSM, timed waits, loops).
// Define WATCHDOG_EN to add the runaway-program instruction watchdog.
module wash_sequencer
  import wash_pkg::*;
#(
  parameter logic [7:0]  START_PC = 8'h00,
  parameter int          WAIT_W   = 20,
  parameter logic [15:0] WDOG_MAX = 16'd4095
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        pause,
  input  logic        abort,
  input  logic        tick,
  output logic [7:0]  pc,
  input  logic [31:0] instr,
  output logic [3:0]  act,
  output logic        busy,
  output logic        done,
  output logic        err
);
  state_t st, ret;
  logic [3:0] op, act_r;
  logic [7:0] addr, loop_cnt, lc_dec, pc_inc, pc_nxt;
  logic [IMM_W-1:0] imm;
  logic [WAIT_W-1:0] wait_cnt;
  logic run, wait_go, expire, wdog_trip;
  assign op = instr[OP_LSB +: 4];
  assign addr = instr[ADDR_LSB +: 8];
  assign imm = instr[IMM_W-1:0];
  assign pc_inc = pc + 8'd1;
  assign lc_dec = loop_cnt - 8'd1;
  assign run = st == S_RUN && !abort && !pause;
  assign wait_go = op == OP_WAIT && imm != '0;
  assign pc_nxt = (op == OP_JMP || (op == OP_DJNZ && lc_dec != 8'd0)) ? addr :
                  (op == OP_HALT || wait_go) ? pc : pc_inc;
  // act is held in act_r across a pause; the pin is forced low while paused for door safety
  assign act = st == S_PAUSE ? 4'd0 : act_r;
  assign busy = st == S_RUN || st == S_WAIT || st == S_PAUSE;
  assign done = st == S_DONE;
  wash_wait_timer #(.W(WAIT_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (abort),
    .load   (run && wait_go),
    .val    (WAIT_W'(imm)),
    .tick   (tick),
    .freeze (st != S_WAIT || pause),
    .cnt    (wait_cnt),
    .expire (expire)
  );
`ifdef WATCHDOG_EN
  logic [15:0] wdog;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wdog <= '0;
    else if (abort || ((st == S_IDLE || st == S_DONE) && start)) wdog <= '0;
    else if (run) wdog <= wdog + 16'd1;
  assign wdog_trip = run && wdog + 16'd1 == WDOG_MAX;
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_MAX;
  assign wdog_trip = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= S_IDLE;
      ret <= S_RUN;
      pc <= '0;
      act_r <= '0;
      err <= 1'b0;
      loop_cnt <= '0;
    end else if (abort) begin
      st <= S_IDLE;
      pc <= '0;
      act_r <= '0;
      loop_cnt <= '0;
    end else begin
      case (st)
        S_IDLE, S_DONE: if (start) begin
          pc <= START_PC;
          err <= 1'b0;
          st <= S_RUN;
        end
        S_RUN: if (pause) begin
          st <= S_PAUSE;
          ret <= S_RUN;
        end else begin
          pc <= pc_nxt;
          if (op == OP_OUT) act_r <= imm[3:0];
          if (op == OP_LDC) loop_cnt <= imm[7:0];
          if (op == OP_DJNZ) loop_cnt <= lc_dec;
          if (wait_go) st <= S_WAIT;
          if (op == OP_HALT) begin
            st <= S_DONE;
            act_r <= '0;
          end
          if (op > OP_HALT) err <= 1'b1;
          if (wdog_trip) begin
            st <= S_DONE;
            act_r <= '0;
            err <= 1'b1;
          end
        end
        S_WAIT: if (pause) begin
          st <= S_PAUSE;
          ret <= S_WAIT;
        end else if (expire) begin
          pc <= pc_inc;
          st <= S_RUN;
        end
        S_PAUSE: if (!pause) st <= ret;
        default: st <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_wash_sequencer.sv
// tb_wash_sequencer: directed program checks plus randomized runs against a behavioural program model
module tb_wash_sequencer;
  import wash_pkg::*;
  logic clk = 0, rst_n = 0, start = 0, pause = 0, abort = 0, tick = 0;
  logic [7:0] pc;
  logic [31:0] instr;
  logic [3:0] act;
  logic busy, done, err;
  logic [31:0] rom [256];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  assign instr = rom[pc];
  wash_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .abort(abort), .tick(tick),
    .pc(pc), .instr(instr), .act(act), .busy(busy), .done(done), .err(err)
  );
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] ins(input int op, input int addr, input int imm);
    logic [3:0] o;
    logic [7:0] a;
    logic [19:0] i;
    o = op[3:0];
    a = addr[7:0];
    i = imm[19:0];
    return {o, a, i};
  endfunction
  // program-level model: mode 0 idle, 1 running, 2 stalled on ticks, 3 finished; pause is a flag on top
  int m_mode, m_pc, m_act, m_lc, m_wc, m_op, m_addr, m_imm;
  bit m_paused, m_err;
  always @(posedge clk or negedge rst_n)
    if (!rst_n || abort) begin
      m_mode = 0; m_paused = 0; m_pc = 0; m_act = 0; m_lc = 0; m_wc = 0;
      if (!rst_n) m_err = 0;
    end else if (m_paused) m_paused = pause;
    else if (pause && (m_mode == 1 || m_mode == 2)) m_paused = 1;
    else if (m_mode == 0 || m_mode == 3) begin
      if (start) begin m_pc = 0; m_err = 0; m_mode = 1; end
    end else if (m_mode == 2) begin
      if (tick) begin
        m_wc--;
        if (m_wc == 0) begin m_pc = (m_pc + 1) % 256; m_mode = 1; end
      end
    end else begin
      m_op = int'(rom[m_pc][31:28]);
      m_addr = int'(rom[m_pc][27:20]);
      m_imm = int'(rom[m_pc][19:0]);
      case (m_op)
        1: begin m_act = m_imm % 16; m_pc = (m_pc + 1) % 256; end
        2: if (m_imm == 0) m_pc = (m_pc + 1) % 256; else begin m_wc = m_imm; m_mode = 2; end
        3: m_pc = m_addr;
        4: begin m_lc = m_imm % 256; m_pc = (m_pc + 1) % 256; end
        5: begin
          m_lc = (m_lc + 255) % 256;
          m_pc = m_lc != 0 ? m_addr : (m_pc + 1) % 256;
        end
        6: begin m_mode = 3; m_act = 0; end
        default: begin
          if (m_op > 6) m_err = 1;
          m_pc = (m_pc + 1) % 256;
        end
      endcase
    end
  always @(negedge clk)
    if (rst_n) begin
      chk("model_pc", pc, m_pc);
      chk("model_act", act, m_paused ? 0 : m_act);
      chk("model_busy", busy, m_paused || m_mode == 1 || m_mode == 2);
      chk("model_done", done, !m_paused && m_mode == 3);
      chk("model_err", err, m_err);
    end
  task automatic step(input bit s, input bit p, input bit a, input bit t);
    start = s; pause = p; abort = a; tick = t;
    @(posedge clk);
    #1;
    start = 0; abort = 0; tick = 0;
  endtask
  task automatic do_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask
  task automatic fill_halt();
    for (int i = 0; i < 256; i++) rom[i] = ins(OP_HALT, 0, 0);
  endtask
  function automatic logic [31:0] rnd_ins(input int amax);
    int sel = $urandom_range(99);
    int a = $urandom_range(amax);
    int r = $urandom_range(20'hFFFFF);
    if (sel < 15) return ins(OP_NOP, a, r);
    if (sel < 35) return ins(OP_OUT, a, r);
    if (sel < 55) return ins(OP_WAIT, a, $urandom_range(5));
    if (sel < 65) return ins(OP_JMP, a, r);
    if (sel < 73) return ins(OP_LDC, a, (r & 32'hFFF00) | $urandom_range(4));
    if (sel < 88) return ins(OP_DJNZ, a, r);
    if (sel < 94) return ins(OP_HALT, a, r);
    return ins($urandom_range(15, 7), a, r);
  endfunction
  initial begin
    int n1;
    bit seen, t, pv;
    logic [63:0] seq;
    int nb;
    // OUT valve, WAIT 3, OUT 0, HALT
    fill_halt();
    rom[0] = ins(OP_OUT, 0, 1 << ACT_VALVE);
    rom[1] = ins(OP_WAIT, 0, 3);
    rom[2] = ins(OP_OUT, 0, 0);
    do_reset();
    chk("rst_pc", pc, 0);
    chk("rst_act", act, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    step(1, 0, 0, 0);
    n1 = 0; seen = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      t = $urandom_range(2) == 0;
      if (pc == 8'd1) begin
        chk("wait_act", act, 1);
        if (seen) n1 += int'(t);
        seen = 1;
      end
      step(0, 0, 0, t);
    end
    chk("wait_ticks", n1, 3);
    chk("p1_done", done, 1);
    chk("p1_pc", pc, 3);
    chk("p1_act", act, 0);
    // LDC 3 / DJNZ loop
    fill_halt();
    rom[0] = ins(OP_LDC, 0, 3);
    rom[1] = ins(OP_OUT, 0, 4);
    rom[2] = ins(OP_DJNZ, 1, 0);
    do_reset();
    step(1, 0, 0, 0);
    seq = '0; nb = 0;
    for (int k = 0; k < 20 && busy; k++) begin
      seq = {seq[55:0], pc};
      nb++;
      step(0, 0, 0, 0);
    end
    chk("loop_seq", seq, 64'h0001020102010203);
    chk("loop_len", nb, 8);
    chk("loop_done", done, 1);
    chk("loop_cnt", dut.loop_cnt, 0);
    // pause for 5 ticks inside WAIT 4
    fill_halt();
    rom[0] = ins(OP_OUT, 0, 5);
    rom[1] = ins(OP_WAIT, 0, 4);
    do_reset();
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("wc_load", dut.wait_cnt, 4);
    step(0, 0, 0, 1);
    repeat (5) step(0, 1, 0, 1);
    chk("pause_act", act, 0);
    chk("pause_busy", busy, 1);
    chk("pause_wc", dut.wait_cnt, 3);
    step(0, 0, 0, 0);
    chk("resume_act", act, 5);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("resume_pc1", pc, 1);
    step(0, 0, 0, 1);
    chk("resume_pc2", pc, 2);
    // abort during WAIT, then restart
    do_reset();
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 1, 1);
    chk("abort_pc", pc, 0);
    chk("abort_act", act, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    step(1, 0, 0, 0);
    chk("restart_busy", busy, 1);
    step(0, 0, 0, 0);
    chk("restart_act", act, 5);
    // asynchronous reset mid-program
    #2 rst_n = 0;
    #1;
    chk("areset_act", act, 0);
    chk("areset_busy", busy, 0);
    chk("areset_pc", pc, 0);
    @(posedge clk);
    #1 rst_n = 1;
    repeat (3) step(0, 0, 0, 1);
    chk("areset_stays", busy, 0);
    // illegal opcode at pc 2
    fill_halt();
    rom[0] = ins(OP_NOP, 0, 0);
    rom[1] = ins(OP_NOP, 0, 0);
    rom[2] = ins(10, 0, 0);
    do_reset();
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("ill_err0", err, 0);
    step(0, 0, 0, 0);
    chk("ill_err1", err, 1);
    chk("ill_pc", pc, 3);
    step(0, 0, 0, 0);
    chk("ill_done", done, 1);
    chk("ill_sticky", err, 1);
    step(1, 0, 0, 0);
    chk("ill_clear", err, 0);
    // randomized programs and operator activity
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 256; i++) rom[i] = rnd_ins(r == 0 ? 31 : 255);
      do_reset();
      pv = 0;
      for (int i = 0; i < 3000; i++) begin
        if (pv) pv = $urandom_range(7) != 0;
        else pv = $urandom_range(59) == 0;
        step($urandom_range(19) == 0, pv, $urandom_range(149) == 0, $urandom_range(2) == 0);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
